mode_scheduler: RTL and testbench

Central mode controller for the alarm-clock design. It owns the shared push-button pulses (mode/set/up/down/next) and steers each one to exactly one consumer: clock core, stopwatch or alarm unit. It tracks the active display mode and an edit lock. A rising alarm match pre-empts the current mode with a timed ring state. Its `st_mux` output selects the active source in the display driver.

---
 rtl/mode_scheduler_if.sv | 44 ++++
 rtl/mode_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mode_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mode_scheduler_if.sv
// Button, tick and alarm inputs plus all routed outputs of the mode scheduler.
interface mode_scheduler_if;
  logic       tick_1hz;
  logic       mode_p;
  logic       set_p;
  logic       up_p;
  logic       down_p;
  logic       next_p;
  logic       alarm_req;
  logic [1:0] st_mux;
  logic       edit;
  logic       ringing;
  logic       core_set;
  logic       core_up;
  logic       core_down;
  logic       stop_run;
  logic       stop_clear;
  logic       stop_lap;
  logic       stop_next;
  logic       alarm_set;
  logic       alarm_up;
  logic       alarm_down;
  logic       alarm_next;
  logic       snooze;
  logic       ring_clear;

  modport slave (
    input  tick_1hz, mode_p, set_p, up_p, down_p, next_p, alarm_req,
    output st_mux, edit, ringing,
    output core_set, core_up, core_down,
    output stop_run, stop_clear, stop_lap, stop_next,
    output alarm_set, alarm_up, alarm_down, alarm_next,
    output snooze, ring_clear
  );

  modport master (
    output tick_1hz, mode_p, set_p, up_p, down_p, next_p, alarm_req,
    input  st_mux, edit, ringing,
    input  core_set, core_up, core_down,
    input  stop_run, stop_clear, stop_lap, stop_next,
    input  alarm_set, alarm_up, alarm_down, alarm_next,
    input  snooze, ring_clear
  );
endinterface

// File: rtl/mode_scheduler.sv
// Central mode controller: routes shared button pulses to one consumer,
// tracks display mode / edit lock, and pre-empts with a timed ring state.
module mode_scheduler #(
  parameter int unsigned RING_TICKS = 30
) (
  input logic             clk,
  input logic             rst,
  mode_scheduler_if.slave bus
);

  // State encoding doubles as the st_mux display select.
  typedef enum logic [1:0] {
    CLOCK = 2'b00,
    STOP  = 2'b01,
    ALARM = 2'b10,
    RING  = 2'b11
  } state_t;

  typedef struct packed {
    logic core_set;
    logic core_up;
    logic core_down;
    logic stop_run;
    logic stop_clear;
    logic stop_lap;
    logic stop_next;
    logic alarm_set;
    logic alarm_up;
    logic alarm_down;
    logic alarm_next;
    logic snooze;
    logic ring_clear;
  } pulse_t;

  localparam logic [7:0] RING_LAST = 8'(RING_TICKS - 1);

  state_t     state, state_n;
  state_t     saved, saved_n;
  logic       edit, edit_n;
  logic [7:0] cnt, cnt_n;
  logic       alarm_prev;
  pulse_t     pulses, pulses_n;
  logic       alarm_rise;
  logic       ring_next;
  logic       ring_down;

  assign alarm_rise = bus.alarm_req & ~alarm_prev;
  // In RING only next/down act, but higher-priority mode/set still consume the cycle.
  assign ring_next  = bus.next_p & ~bus.mode_p & ~bus.set_p;
  assign ring_down  = bus.down_p & ~bus.mode_p & ~bus.set_p & ~bus.next_p;

  // State, edit lock, ring counter and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLOCK;
      saved      <= CLOCK;
      edit       <= 1'b0;
      cnt        <= '0;
      alarm_prev <= 1'b1;
      pulses     <= '0;
    end else begin
      state      <= state_n;
      saved      <= saved_n;
      edit       <= edit_n;
      cnt        <= cnt_n;
      alarm_prev <= bus.alarm_req;
      pulses     <= pulses_n;
    end
  end

  // Next-state and pulse routing with strict single-pulse priority.
  always_comb begin
    state_n  = state;
    saved_n  = saved;
    edit_n   = edit;
    cnt_n    = cnt;
    pulses_n = '0;
    if (alarm_rise && state != RING) begin
      saved_n = state;
      edit_n  = 1'b0;
      cnt_n   = '0;
      state_n = RING;
    end else begin
      case (state)
        CLOCK: begin
          if (bus.mode_p) begin
            if (!edit) state_n = STOP;
          end else if (bus.set_p) begin
            edit_n            = ~edit;
            pulses_n.core_set = 1'b1;
          end else if (bus.next_p) begin
            pulses_n = '0;
          end else if (bus.down_p) begin
            pulses_n.core_down = edit;
          end else if (bus.up_p) begin
            pulses_n.core_up = edit;
          end
        end
        STOP: begin
          if (bus.mode_p) begin
            state_n = ALARM;
          end else if (bus.set_p) begin
            pulses_n.stop_run = 1'b1;
          end else if (bus.next_p) begin
            pulses_n.stop_next = 1'b1;
          end else if (bus.down_p) begin
            pulses_n.stop_lap = 1'b1;
          end else if (bus.up_p) begin
            pulses_n.stop_clear = 1'b1;
          end
        end
        ALARM: begin
          if (bus.mode_p) begin
            if (!edit) state_n = CLOCK;
          end else if (bus.set_p) begin
            edit_n             = ~edit;
            pulses_n.alarm_set = 1'b1;
          end else if (bus.next_p) begin
            pulses_n.alarm_next = 1'b1;
          end else if (bus.down_p) begin
            pulses_n.alarm_down = edit;
          end else if (bus.up_p) begin
            pulses_n.alarm_up = edit;
          end
        end
        default: begin
          if (bus.tick_1hz) cnt_n = cnt + 8'd1;
          if (ring_next) begin
            pulses_n.snooze = 1'b1;
            state_n         = saved;
            edit_n          = 1'b0;
          end else if (ring_down) begin
            pulses_n.ring_clear = 1'b1;
            state_n             = saved;
            edit_n              = 1'b0;
          end else if (bus.tick_1hz && cnt == RING_LAST) begin
            pulses_n.ring_clear = 1'b1;
            state_n             = saved;
            edit_n              = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.st_mux     = state;
  assign bus.edit       = edit;
  assign bus.ringing    = (state == RING);
  assign bus.core_set   = pulses.core_set;
  assign bus.core_up    = pulses.core_up;
  assign bus.core_down  = pulses.core_down;
  assign bus.stop_run   = pulses.stop_run;
  assign bus.stop_clear = pulses.stop_clear;
  assign bus.stop_lap   = pulses.stop_lap;
  assign bus.stop_next  = pulses.stop_next;
  assign bus.alarm_set  = pulses.alarm_set;
  assign bus.alarm_up   = pulses.alarm_up;
  assign bus.alarm_down = pulses.alarm_down;
  assign bus.alarm_next = pulses.alarm_next;
  assign bus.snooze     = pulses.snooze;
  assign bus.ring_clear = pulses.ring_clear;

endmodule

// File: tb/tb_mode_scheduler.sv
// Testbench for mode_scheduler: table-driven reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mode_scheduler;

  localparam int RT = 3;

  // Pulse vector bit indices used by the model's routing table.
  localparam int P_CORE_SET = 0, P_CORE_UP = 1, P_CORE_DOWN = 2;
  localparam int P_STOP_RUN = 3, P_STOP_CLEAR = 4, P_STOP_LAP = 5, P_STOP_NEXT = 6;
  localparam int P_ALARM_SET = 7, P_ALARM_UP = 8, P_ALARM_DOWN = 9, P_ALARM_NEXT = 10;
  localparam int P_SNOOZE = 11, P_RING_CLEAR = 12;

  // Button vector order is priority order: mode, set, next, down, up.
  localparam logic [4:0] B_NONE = 5'b00000, B_MODE = 5'b10000, B_SET = 5'b01000;
  localparam logic [4:0] B_NEXT = 5'b00100, B_DOWN = 5'b00010, B_UP = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  mode_scheduler_if bus();

  mode_scheduler #(.RING_TICKS(RT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] dut_pulse;
  assign dut_pulse = {bus.ring_clear, bus.snooze, bus.alarm_next, bus.alarm_down,
                      bus.alarm_up, bus.alarm_set, bus.stop_next, bus.stop_lap,
                      bus.stop_clear, bus.stop_run, bus.core_down, bus.core_up,
                      bus.core_set};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          route [3][5];
  int          m_mode, m_saved, m_cnt;
  bit          m_edit, m_prev, m_valid;
  logic [12:0] m_pulse;

  initial begin
    route[0] = '{-1, P_CORE_SET,  -1,           P_CORE_DOWN,  P_CORE_UP};
    route[1] = '{-1, P_STOP_RUN,  P_STOP_NEXT,  P_STOP_LAP,   P_STOP_CLEAR};
    route[2] = '{-1, P_ALARM_SET, P_ALARM_NEXT, P_ALARM_DOWN, P_ALARM_UP};
  end

  always @(posedge clk) begin
    logic [4:0] b;
    int btn, idx;
    bit fin;
    b = {bus.mode_p, bus.set_p, bus.next_p, bus.down_p, bus.up_p};
    btn = -1;
    for (int i = 0; i < 5; i++)
      if (btn < 0 && b[4-i]) btn = i;
    m_pulse = '0;
    if (rst) begin
      m_mode = 0; m_saved = 0; m_cnt = 0; m_edit = 0; m_prev = 1; m_valid = 1;
    end else begin
      if (bus.alarm_req && !m_prev && m_mode != 3) begin
        m_saved = m_mode; m_mode = 3; m_edit = 0; m_cnt = 0;
      end else if (m_mode == 3) begin
        fin = 0;
        if (bus.tick_1hz) m_cnt++;
        if (btn == 2) begin m_pulse[P_SNOOZE] = 1; fin = 1; end
        else if (btn == 3) begin m_pulse[P_RING_CLEAR] = 1; fin = 1; end
        else if (bus.tick_1hz && m_cnt == RT) begin m_pulse[P_RING_CLEAR] = 1; fin = 1; end
        if (fin) begin m_mode = m_saved; m_edit = 0; end
      end else if (btn == 0) begin
        if (!m_edit) m_mode = (m_mode + 1) % 3;
      end else if (btn > 0) begin
        idx = route[m_mode][btn];
        // up/down in an editable mode only count while editing
        if (m_mode != 1 && btn >= 3 && !m_edit) idx = -1;
        if (m_mode != 1 && btn == 1) m_edit = !m_edit;
        if (idx >= 0) m_pulse[idx] = 1;
      end
      m_prev = bus.alarm_req;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model st_mux", int'(bus.st_mux), m_mode);
      chk("model edit", int'(bus.edit), int'(m_edit));
      chk("model ringing", int'(bus.ringing), int'(m_mode == 3));
      chk("model pulses", int'(dut_pulse), int'(m_pulse));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [4:0] b, input logic tk);
    {bus.mode_p, bus.set_p, bus.next_p, bus.down_p, bus.up_p} = b;
    bus.tick_1hz = tk;
    @(negedge clk);
    {bus.mode_p, bus.set_p, bus.next_p, bus.down_p, bus.up_p} = '0;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    m_valid = 0;
    {bus.mode_p, bus.set_p, bus.next_p, bus.down_p, bus.up_p} = '0;
    bus.tick_1hz  = 1'b0;
    bus.alarm_req = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("reset st_mux", int'(bus.st_mux), 0);
    chk("reset edit", int'(bus.edit), 0);
    chk("reset ringing", int'(bus.ringing), 0);
    chk("reset pulses", int'(dut_pulse), 0);

    // Mode cycling CLOCK -> STOP -> ALARM -> CLOCK
    drive(B_MODE, 0); chk("cycle to STOP", int'(bus.st_mux), 1); idle(9);
    drive(B_MODE, 0); chk("cycle to ALARM", int'(bus.st_mux), 2); idle(9);
    drive(B_MODE, 0); chk("cycle to CLOCK", int'(bus.st_mux), 0); idle(9);

    // CLOCK editing
    drive(B_UP, 0);   chk("up w/o edit dropped", int'(dut_pulse), 0);
    drive(B_SET, 0);  chk("core_set", int'(bus.core_set), 1); chk("edit on", int'(bus.edit), 1);
    drive(B_UP, 0);   chk("core_up", int'(bus.core_up), 1);
    drive(B_MODE, 0); chk("mode locked", int'(bus.st_mux), 0);
    drive(B_SET, 0);  chk("core_set 2", int'(bus.core_set), 1); chk("edit off", int'(bus.edit), 0);
    drive(B_MODE, 0); chk("to STOP", int'(bus.st_mux), 1);

    // STOP routing
    drive(B_SET, 0);  chk("stop_run", int'(bus.stop_run), 1);
    drive(B_DOWN, 0); chk("stop_lap", int'(bus.stop_lap), 1);
    drive(B_UP, 0);   chk("stop_clear", int'(bus.stop_clear), 1);
    drive(B_NEXT, 0); chk("stop_next", int'(bus.stop_next), 1);
    drive(B_SET | B_DOWN, 0);
    chk("coincident only run", int'(dut_pulse), 1 << P_STOP_RUN);

    // ALARM edit pre-empted by ring, snooze back
    drive(B_MODE, 0); chk("to ALARM", int'(bus.st_mux), 2);
    drive(B_SET, 0);  chk("alarm_set", int'(bus.alarm_set), 1);
    bus.alarm_req = 1'b1;
    idle(1);
    chk("ring st_mux", int'(bus.st_mux), 3);
    chk("ring edit", int'(bus.edit), 0);
    chk("ring ringing", int'(bus.ringing), 1);
    chk("ring entry no pulse", int'(dut_pulse), 0);
    drive(B_NEXT, 0); chk("snooze", int'(bus.snooze), 1); chk("back ALARM", int'(bus.st_mux), 2);
    idle(5);
    chk("no re-ring", int'(bus.st_mux), 2);
    bus.alarm_req = 1'b0;
    drive(B_MODE, 0); chk("ALARM to CLOCK", int'(bus.st_mux), 0);
    drive(B_MODE, 0); chk("CLOCK to STOP", int'(bus.st_mux), 1);

    // Auto-clear from STOP after RT ticks
    bus.alarm_req = 1'b1;
    idle(1);
    chk("ring from STOP", int'(bus.st_mux), 3);
    drive(B_NONE, 1); idle(1);
    drive(B_NONE, 1); chk("still ringing", int'(bus.st_mux), 3); idle(1);
    drive(B_NONE, 1);
    chk("auto ring_clear", int'(bus.ring_clear), 1);
    chk("auto back STOP", int'(bus.st_mux), 1);
    idle(1);
    chk("ring_clear single", int'(bus.ring_clear), 0);

    // Down coincident with final tick gives one ring_clear
    bus.alarm_req = 1'b0; idle(1);
    bus.alarm_req = 1'b1; idle(1);
    chk("re-enter ring", int'(bus.st_mux), 3);
    drive(B_NONE, 1); drive(B_NONE, 1);
    drive(B_DOWN, 1);
    chk("coincident clear", int'(dut_pulse), 1 << P_RING_CLEAR);
    chk("coincident back STOP", int'(bus.st_mux), 1);
    idle(1);
    chk("no second clear", int'(bus.ring_clear), 0);

    // Alarm held through reset: no ring
    rst = 1'b1; idle(2); rst = 1'b0; idle(3);
    chk("held alarm no ring", int'(bus.ringing), 0);
    chk("held alarm st_mux", int'(bus.st_mux), 0);

    // Reset mid-ring
    bus.alarm_req = 1'b0; idle(1);
    bus.alarm_req = 1'b1; idle(1);
    chk("ring from CLOCK", int'(bus.st_mux), 3);
    rst = 1'b1;
    drive(B_NEXT, 0);
    chk("reset mid-ring st_mux", int'(bus.st_mux), 0);
    chk("reset mid-ring ringing", int'(bus.ringing), 0);
    chk("reset mid-ring pulses", int'(dut_pulse), 0);
    rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
